// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory port between the CPU bus interface and a DMA/debug
// master. The CPU has fixed priority. A starvation counter lets the DMA
// master win once it has lost STARVE_LIMIT arbitrations while requesting.
//
// Each access takes three states:
//   IDLE   -> arbitration
//   ACCESS -> mem_en is high for this single cycle
//   DONE   -> the owner's ack pulses, and arbitration runs again
// From DONE a new grant can follow at once, giving one access per 2 cycles.
//
// Ports
//   clk, reset_n                        clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  -> cpu_ack, cpu_rdata, cpu_rdy   CPU requester
//   dma_req/we/addr/wdata  -> dma_ack, dma_rdata            DMA requester
//   mem_en/we/addr/wdata, mem_rdata     memory port
//   owner_dma                           current or last grant (1 = DMA)
//   busy                                FSM is not in IDLE
module mem_bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner_dma,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       arb_point;
  logic       cpu_elig, dma_elig;
  logic       starve_full;
  logic       dma_win, cpu_win;

  // The control unit stalls while its request is outstanding.
  assign cpu_rdy = !(cpu_req && !cpu_ack);

  always_comb begin
    arb_point   = (state == IDLE) || (state == DONE);
    // The ack is high exactly in DONE for the owner. Masking that
    // requester keeps a req still held from the previous access from
    // being granted a second time.
    cpu_elig    = cpu_req && !cpu_ack;
    dma_elig    = dma_req && !dma_ack;
    starve_full = (starve_cnt == 4'(STARVE_LIMIT));
    dma_win     = arb_point && dma_elig && (!cpu_elig || starve_full);
    cpu_win     = arb_point && cpu_elig && !dma_win;

    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE, DONE: state_nxt = (dma_win || cpu_win) ? ACCESS : IDLE;
      ACCESS:     state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase

    if (arb_point) begin
      if (dma_win || !dma_req)
        starve_nxt = 4'd0;
      else if (cpu_win && !starve_full)
        starve_nxt = starve_cnt + 4'd1;
    end
  end

  // ---- grant / access / completion registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner_dma  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      busy       <= (state_nxt != IDLE);
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      if (state == ACCESS) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (owner_dma) dma_ack <= 1'b1;
        else           cpu_ack <= 1'b1;
        // mem_we still holds the access type during ACCESS.
        if (!mem_we) begin
          if (owner_dma) dma_rdata <= mem_rdata;
          else           cpu_rdata <= mem_rdata;
        end
      end else if (dma_win) begin
        mem_en    <= 1'b1;
        mem_we    <= dma_we;
        mem_addr  <= dma_addr;
        mem_wdata <= dma_wdata;
        owner_dma <= 1'b1;
      end else if (cpu_win) begin
        mem_en    <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        owner_dma <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by randomized
// traffic. A transaction-level reference model tracks the expected bus state.
module tb_mem_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_ack, cpu_rdy, dma_ack;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_en, mem_we, owner_dma, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner_dma(owner_dma), .busy(busy)
  );

  // Memory: read data follows the presented address while the access is
  // in progress, and writes commit at the end of the access cycle.
  logic [DW-1:0] ram [0:65535];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Reference model state.
  logic [DW-1:0] mm [0:65535];
  int            phase;          // 0 idle, 1 memory cycle, 2 completion
  bit            own_dma;
  int            lost;           // DMA losses while requesting
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  logic [DW-1:0] exp_crd, exp_drd;
  bit            exp_cack, exp_dack, exp_en;

  int vectors = 0;
  int errs    = 0;

  task automatic model_reset();
    phase = 0; own_dma = 0; lost = 0;
    t_we = 0; t_addr = '0; t_data = '0;
    exp_crd = '0; exp_drd = '0;
    exp_cack = 0; exp_dack = 0; exp_en = 0;
  endtask

  task automatic model_step();
    bit c_in, d_in;
    int who;
    if (phase == 1) begin
      if (t_we) mm[t_addr] = t_data;
      else if (own_dma) exp_drd = mm[t_addr];
      else exp_crd = mm[t_addr];
      exp_cack = !own_dma;
      exp_dack = own_dma;
      exp_en   = 0;
      phase    = 2;
    end else begin
      // Whoever is being acknowledged now does not compete.
      c_in = cpu_req && !(phase == 2 && !own_dma);
      d_in = dma_req && !(phase == 2 && own_dma);
      who = 0;
      if (d_in && (!c_in || lost == SL)) who = 2;
      else if (c_in) who = 1;
      if (who == 2 || !dma_req) lost = 0;
      else if (who == 1 && lost < SL) lost = lost + 1;
      exp_cack = 0;
      exp_dack = 0;
      if (who == 2) begin
        own_dma = 1; t_we = dma_we; t_addr = dma_addr; t_data = dma_wdata;
      end else if (who == 1) begin
        own_dma = 0; t_we = cpu_we; t_addr = cpu_addr; t_data = cpu_wdata;
      end
      exp_en = (who != 0);
      phase  = (who != 0) ? 1 : 0;
    end
  endtask

  task automatic check();
    logic [6:0] want_ctl;
    want_ctl = {exp_en, exp_en && t_we, exp_cack, exp_dack, own_dma,
                phase != 0, !(cpu_req && !exp_cack)};
    vectors++;
    assert ({mem_en, mem_we, cpu_ack, dma_ack, owner_dma, busy, cpu_rdy} === want_ctl)
      else begin
        errs++;
        $error("FAIL ctl observed %b expected %b", {mem_en, mem_we, cpu_ack, dma_ack,
               owner_dma, busy, cpu_rdy}, want_ctl);
      end
    vectors++;
    assert ({mem_addr, mem_wdata} === {t_addr, t_data})
      else begin
        errs++;
        $error("FAIL membus observed %h expected %h", {mem_addr, mem_wdata}, {t_addr, t_data});
      end
    vectors++;
    assert ({cpu_rdata, dma_rdata} === {exp_crd, exp_drd})
      else begin
        errs++;
        $error("FAIL rdata observed %h expected %h", {cpu_rdata, dma_rdata}, {exp_crd, exp_drd});
      end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want)
      else begin
        errs++;
        $error("FAIL %s observed %h expected %h", tag, got, want);
      end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    @(negedge clk);
    check();
  endtask

  initial begin
    logic [DW-1:0] v;
    reset_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    pre_en = 0; pre_addr = '0; pre_data = '0;
    model_reset();
    @(negedge clk);

    // Preload memory while held in reset.
    for (int i = 0; i < 10; i++) begin
      pre_en = 1;
      if (i < 8) begin
        pre_addr = AW'(i);
        v = DW'($urandom);
      end else if (i == 8) begin
        pre_addr = 16'h1234; v = 8'hA9;
      end else begin
        pre_addr = 16'h0200; v = 8'h00;
      end
      pre_data = v;
      mm[pre_addr] = v;
      cycle();
    end
    pre_en = 0;
    expect_eq("reset_busy", 32'(busy), 32'd0);
    expect_eq("reset_outs", 32'({mem_en, cpu_ack, dma_ack, owner_dma, cpu_rdata, dma_rdata}), 32'd0);
    reset_n = 1;
    cycle();

    // CPU read of 0x1234.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    #1 expect_eq("rdy_waiting", 32'(cpu_rdy), 32'd0);
    cycle();
    expect_eq("cpu_rd_en", 32'({mem_en, mem_we}), 32'b10);
    expect_eq("cpu_rd_addr", 32'(mem_addr), 32'h1234);
    cycle();
    expect_eq("cpu_rd_ack", 32'({cpu_ack, cpu_rdy}), 32'b11);
    expect_eq("cpu_rd_data", 32'(cpu_rdata), 32'hA9);
    cpu_req = 0;
    cycle();
    expect_eq("cpu_rd_idle", 32'(busy), 32'd0);

    // DMA write of 0x5A to 0x0200, then CPU read-back.
    dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 8'h5A;
    cycle();
    expect_eq("dma_wr_en", 32'({mem_en, mem_we, owner_dma}), 32'b111);
    cycle();
    expect_eq("dma_wr_ack", 32'({dma_ack, mem_en, mem_we}), 32'b100);
    expect_eq("dma_wr_cpu_rdata", 32'(cpu_rdata), 32'hA9);
    dma_req = 0;
    cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
    cycle();
    cycle();
    expect_eq("readback", 32'({cpu_ack, cpu_rdata}), 32'h15A);
    cpu_req = 0;
    cycle();

    // Simultaneous requests: CPU first, DMA at the next arbitration.
    cpu_req = 1; cpu_addr = 16'h0003; dma_req = 1; dma_we = 0; dma_addr = 16'h0005;
    cycle();
    expect_eq("simul_cpu_first", 32'({mem_en, owner_dma}), 32'b10);
    cycle();
    expect_eq("simul_cpu_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 0;
    cycle();
    expect_eq("simul_dma_grant", 32'({mem_en, owner_dma}), 32'b11);
    cycle();
    expect_eq("simul_dma_ack", 32'({dma_ack, cpu_ack}), 32'b10);
    dma_req = 0;
    cycle();

    // Both requests held continuously.
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 20; i++) cycle();
    cpu_req = 0; dma_req = 0;
    cycle(); cycle();

    // Reset while an access is in progress.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0004;
    cycle();
    expect_eq("pre_reset_access", 32'(mem_en), 32'd1);
    reset_n = 0;
    #1;
    model_reset();
    expect_eq("reset_abort", 32'({mem_en, busy, cpu_ack}), 32'd0);
    cycle();
    reset_n = 1;
    cycle();
    expect_eq("after_reset_grant", 32'(mem_en), 32'd1);
    cycle();
    expect_eq("after_reset_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 0;
    cycle();

    // Request withdrawn during the memory cycle.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0006; cpu_wdata = 8'h77;
    cycle();
    cpu_req = 0;
    cycle();
    expect_eq("withdrawn_ack", 32'(cpu_ack), 32'd1);
    cycle();
    expect_eq("withdrawn_no_regrant", 32'({busy, mem_en, cpu_ack}), 32'd0);
    cycle();

    // Randomized traffic, including early drops and address changes.
    for (int i = 0; i < 800; i++) begin
      if (!cpu_req || cpu_ack || $urandom_range(0, 15) == 0) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = AW'($urandom_range(0, 7));
        cpu_wdata = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        cpu_addr = AW'($urandom_range(0, 7));
      end
      if (!dma_req || dma_ack || $urandom_range(0, 15) == 0) begin
        dma_req   = ($urandom_range(0, 2) != 0);
        dma_we    = $urandom_range(0, 1) == 1;
        dma_addr  = AW'($urandom_range(0, 7));
        dma_wdata = DW'($urandom);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
